mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of address and data buses (matches the memory unit).
REQ-002 Parameter MEM_LAT, default 1, range 1..15, number of ACCESS cycles per memory transaction.
REQ-003 clk  input  1  single rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-low reset; low forces the reset state immediately.
REQ-005 ifu_req_i  input  1  instruction-fetch read request, level, held until ifu_ack_o.
REQ-006 ifu_addr_i  input  DATA_WIDTH  fetch address.
REQ-007 ifu_ack_o  output  1  one-cycle pulse, fetch complete.
REQ-008 ifu_rdata_o  output  DATA_WIDTH  registered fetch data, held until the next fetch ack.
REQ-009 lsu_req_i  input  1  load/store request, level, held until lsu_ack_o.
REQ-010 lsu_we_i  input  1  1 = store, 0 = load.
REQ-011 lsu_addr_i  input  DATA_WIDTH  load/store address.
REQ-012 lsu_wdata_i  input  DATA_WIDTH  store data.
REQ-013 lsu_ack_o  output  1  one-cycle pulse, load/store complete.
REQ-014 lsu_rdata_o  output  DATA_WIDTH  registered load data, held until the next load ack.
REQ-015 mem_we_o  output  1  write enable to the memory unit WE_i.
REQ-016 mem_addr_o  output  DATA_WIDTH  to memory unit ADDR_i.
REQ-017 mem_wd_o  output  DATA_WIDTH  to memory unit WD_i.
REQ-018 mem_rd_i  input  DATA_WIDTH  from memory unit RD_o (combinational read).
REQ-019 busy_o  output  1  high in ACCESS and ACK states.
REQ-020 owner_o  output  1  current or last grant: 0 = IFU, 1 = LSU.

Function
REQ-021 The FSM SHALL have exactly three states, IDLE, ACCESS and ACK, with IDLE as the reset state.
REQ-022 In IDLE with no request asserted, the FSM SHALL remain in IDLE and drive mem_we_o = 0.
REQ-023 In IDLE with any request asserted, the FSM SHALL:
- grant one requester;
- latch its address, we and wdata into internal registers (IFU we = 0, wdata = 0);
- set owner_o;
- load the cycle counter with MEM_LAT-1;
- go to ACCESS.
REQ-024 When both requests are asserted in IDLE, the grant SHALL go to the requester not granted last (round-robin); after reset the LSU wins the first tie.
REQ-025 A lone request SHALL be granted regardless of the round-robin pointer; the pointer SHALL update on every grant.
REQ-026 In ACCESS, mem_addr_o and mem_wd_o SHALL come from the latched registers, stable for the whole transaction.
REQ-027 mem_we_o SHALL be high only in the first ACCESS cycle of a store: exactly one pulse per store, never for loads or fetches.
REQ-028 ACCESS SHALL last exactly MEM_LAT cycles, with the counter decrementing each cycle.
REQ-029 In the last ACCESS cycle, a read SHALL capture mem_rd_i into the owner's rdata register, and the FSM SHALL go to ACK.
REQ-030 In ACK, the owner's ack SHALL pulse for one cycle and the FSM SHALL return to IDLE; the other port's ack and rdata SHALL stay unchanged.
REQ-031 Latency: a request first sampled in IDLE cycle T SHALL ack in cycle T+MEM_LAT+1, which is T+2 for MEM_LAT = 1.
REQ-032 Requests SHALL be ignored in ACCESS and ACK; changes to an input during a transaction SHALL not affect it.
REQ-033 A request still high in the IDLE cycle after its ack SHALL be treated as a new request; back-to-back transactions therefore have one IDLE cycle between them.
REQ-034 With both requests held continuously, grants SHALL alternate LSU, IFU, LSU, ... with no starvation.
REQ-035 A store SHALL pulse lsu_ack_o and SHALL leave lsu_rdata_o unchanged.
REQ-036 When idle, mem_addr_o and mem_wd_o SHALL hold the last latched values.

Reset
REQ-037 While reset is low, all of the following SHALL hold:
- state is IDLE;
- mem_we_o, ifu_ack_o, lsu_ack_o, busy_o and owner_o are 0;
- mem_addr_o, mem_wd_o, ifu_rdata_o and lsu_rdata_o are 0;
- the round-robin pointer is set so the LSU wins the next tie;
- the counter is 0.
REQ-038 Reset asserted mid-transaction SHALL abort it with no ack and SHALL drop mem_we_o asynchronously; the first grant SHALL be evaluated in the first IDLE cycle after reset is released.

Verification
REQ-039 MEM_LAT=1, only ifu_req_i high at cycle T with address 0x0040_0000 and memory word 0x2008_0005 -> ifu_ack_o at T+2, ifu_rdata_o = 0x2008_0005, mem_we_o never high.
REQ-040 Store: lsu_we_i = 1, address 0x1001_0004, data 0xDEAD_BEEF -> one mem_we_o pulse at T+1 with that address and data, lsu_ack_o at T+2; a following load of 0x1001_0004 returns 0xDEAD_BEEF.
REQ-041 Both requests held from reset release -> grant order LSU, IFU, LSU, IFU with owner_o toggling, each ack spaced 3 cycles apart.
REQ-042 MEM_LAT=3, single load -> busy_o high 4 cycles, ack at T+4, and mem_addr_o stable even though lsu_addr_i changes during ACCESS.
REQ-043 reset driven low during ACCESS of a store with MEM_LAT=3 -> mem_we_o 0 immediately, no ack, all outputs 0; after release, a held request is granted in the first IDLE cycle.
REQ-044 Repeated back-to-back IFU requests -> one IDLE cycle between transactions, and lsu_rdata_o unchanged throughout.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter in front of a single-ported memory.
// Round-robin on ties, fixed MEM_LAT access window, one-cycle ack per transaction.
module mem_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ifu_req_i,
  input  logic [DATA_WIDTH-1:0] ifu_addr_i,
  output logic                  ifu_ack_o,
  output logic [DATA_WIDTH-1:0] ifu_rdata_o,
  input  logic                  lsu_req_i,
  input  logic                  lsu_we_i,
  input  logic [DATA_WIDTH-1:0] lsu_addr_i,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
  output logic                  lsu_ack_o,
  output logic [DATA_WIDTH-1:0] lsu_rdata_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wd_o,
  input  logic [DATA_WIDTH-1:0] mem_rd_i,
  output logic                  busy_o,
  output logic                  owner_o
);

  localparam int unsigned      CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    lsu_prio_q, lsu_prio_d;
  logic                    owner_q, owner_d;
  logic                    we_q, we_d;
  logic [DATA_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wd_q, wd_d;
  logic [DATA_WIDTH-1:0]   ifu_rdata_q, ifu_rdata_d;
  logic [DATA_WIDTH-1:0]   lsu_rdata_q, lsu_rdata_d;
  logic                    ifu_ack_q, ifu_ack_d;
  logic                    lsu_ack_q, lsu_ack_d;
  logic                    mem_we_q, mem_we_d;
  logic                    busy_q, busy_d;
  logic                    grant_lsu;

  // State and output registers; lsu_prio resets high so the LSU wins the first tie
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lsu_prio_q  <= 1'b1;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wd_q        <= '0;
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
      ifu_ack_q   <= 1'b0;
      lsu_ack_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lsu_prio_q  <= lsu_prio_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wd_q        <= wd_d;
      ifu_rdata_q <= ifu_rdata_d;
      lsu_rdata_q <= lsu_rdata_d;
      ifu_ack_q   <= ifu_ack_d;
      lsu_ack_q   <= lsu_ack_d;
      mem_we_q    <= mem_we_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic; *_d of the pulse outputs describe the upcoming state
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lsu_prio_d  = lsu_prio_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wd_d        = wd_q;
    ifu_rdata_d = ifu_rdata_q;
    lsu_rdata_d = lsu_rdata_q;
    ifu_ack_d   = 1'b0;
    lsu_ack_d   = 1'b0;
    mem_we_d    = 1'b0;
    busy_d      = 1'b0;
    grant_lsu   = 1'b0;

    case (state_q)
      IDLE: begin
        if (ifu_req_i || lsu_req_i) begin
          grant_lsu  = lsu_req_i && (!ifu_req_i || lsu_prio_q);
          owner_d    = grant_lsu;
          lsu_prio_d = !grant_lsu;
          addr_d     = grant_lsu ? lsu_addr_i : ifu_addr_i;
          wd_d       = grant_lsu ? lsu_wdata_i : '0;
          we_d       = grant_lsu && lsu_we_i;
          mem_we_d   = grant_lsu && lsu_we_i;
          cnt_d      = CNT_LOAD;
          busy_d     = 1'b1;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        busy_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = ACK;
          if (!we_q) begin
            if (owner_q) lsu_rdata_d = mem_rd_i;
            else         ifu_rdata_d = mem_rd_i;
          end
          lsu_ack_d = owner_q;
          ifu_ack_d = !owner_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ifu_ack_o   = ifu_ack_q;
  assign ifu_rdata_o = ifu_rdata_q;
  assign lsu_ack_o   = lsu_ack_q;
  assign lsu_rdata_o = lsu_rdata_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wd_o    = wd_q;
  assign busy_o      = busy_q;
  assign owner_o     = owner_q;

endmodule
